div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
- Initiator-side controller for the multicycle `div` unit.
- Accepts a divide request from the processor control unit, latches operands, drives the `div` start handshake, and waits for completion.
- Commits quotient to LO and remainder to HI, or flags divide-by-zero.
- Owns the HI/LO architectural registers (mfhi/mflo/mthi/mtlo) and stalls the pipeline while a divide is in flight.

Parameters:
- WIDTH, 32, operand/result width.
- TIMEOUT, 64, max cycles in WAIT before abort (≥2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- req  in  1  one-cycle divide request from control unit.
- op_a  in  WIDTH  dividend (signed).
- op_b  in  WIDTH  divisor (signed).
- hi_we  in  1  mthi write enable.
- lo_we  in  1  mtlo write enable.
- wdata  in  WIDTH  mthi/mtlo data.
- div_start  out  1  start pulse to `div`.
- div_a  out  WIDTH  dividend to `div`.
- div_b  out  WIDTH  divisor to `div`.
- div_busy  in  1  `div` computing.
- div_done  in  1  `div` result-valid pulse.
- div_dbz  in  1  `div` divide-by-zero, qualified by div_done.
- div_val  in  WIDTH  `div` quotient.
- div_rem  in  WIDTH  `div` remainder.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- stall  out  1  pipeline stall.
- ack  out  1  one-cycle pulse: divide committed.
- dbz_exc  out  1  one-cycle pulse: divide by zero.
- tmo_err  out  1  one-cycle pulse: timeout abort.

Behaviour:
- Reset (rst=0, any time including mid-operation):
  - state=IDLE.
  - hi, lo, div_a, div_b = 0.
  - div_start, ack, dbz_exc, tmo_err = 0.
  - Timeout counter = 0.
- Reset takes effect immediately. The `div` unit is reset by the same rst, so no abort handshake is needed.
- States:
  - IDLE: req=1 → latch op_a/op_b into div_a/div_b; go to ISSUE.
  - ISSUE: div_start=1 for exactly this cycle; go to WAIT; clear counter.
  - WAIT: counter increments each cycle.
    - div_done=1 → go to WRITE.
    - Else if counter reaches TIMEOUT-1 → tmo_err pulse; go to IDLE.
  - WRITE:
    - div_dbz was 0 → lo←div_val, hi←div_rem, ack=1.
    - div_dbz was 1 → hi/lo unchanged, dbz_exc=1.
    - Go to IDLE.
- div_val/div_rem/div_dbz are sampled into internal registers on the div_done cycle and committed in WRITE. `div` is not required to hold them after done.
- div_done and timeout in the same cycle: done wins.
- div_busy is ignored for sequencing; it is checked only by assertions (must be 1 in cycles after ISSUE until done).
- stall = (state != IDLE) | req. Combinational; high from the request cycle through WRITE inclusive.
- req while state != IDLE: ignored (control unit is stalled, so a legal design never does this).
- hi_we/lo_we: honoured only in IDLE with req=0. hi/lo update at the next edge. Dropped in any other state or when req=1.
- Latency: req at cycle 0 → div_start at cycle 1 → done at cycle 1+N → hi/lo visible and ack at cycle 2+N.
- div_a/div_b hold the latched operands from ISSUE until the next accepted req.
- Arithmetic: none local; results are passed bit-exact. `div` implements signed truncating division; remainder takes the dividend's sign.

Test Plan:
- Reset mid-WAIT: req op_a=100, op_b=7, then rst=0 two cycles later → immediately state IDLE, stall=0, hi=lo=0. After release, a new req 100/7 completes with lo=14, hi=2.
- Basic: rst, then req op_a=7, op_b=3 with div model latency 33 → div_start high one cycle; stall high 36 cycles; ack one pulse; lo=2, hi=1.
- Signed: op_a=-9 (0xFFFFFFF7), op_b=2 → lo=0xFFFFFFFC (-4), hi=0xFFFFFFFF (-1). Also op_a=9000, op_b=-4 → lo=-2250, hi=0.
- Divide by zero: preset hi=0x11, lo=0x22 via mthi/mtlo, then req op_a=5000, op_b=0, model asserts dbz with done → dbz_exc one pulse, ack=0, hi=0x11, lo=0x22 unchanged.
- Timeout: model never asserts done, TIMEOUT=64 → tmo_err pulses exactly 64 cycles after the div_start cycle; stall drops the next cycle; hi/lo unchanged.
- Illegal writes dropped: hi_we=1, wdata=0xDEAD during WAIT, and a second req during WAIT → both ignored; result of the first divide (1000/7: lo=142, hi=6) is committed, with a single ack.

Source files
------------

// File: rtl/div_ctrl.sv
// div_ctrl: initiator-side controller for the multicycle divider.
// Latches operands on a request, pulses div_start, waits for div_done
// (bounded by TIMEOUT) and commits quotient/remainder to LO/HI. It also
// owns the HI/LO architectural registers for mthi/mtlo and stalls the
// pipeline while a divide is in flight.
module div_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             div_start,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic             div_busy,
    input  logic             div_done,
    input  logic             div_dbz,
    input  logic [WIDTH-1:0] div_val,
    input  logic [WIDTH-1:0] div_rem,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             stall,
    output logic             ack,
    output logic             dbz_exc,
    output logic             tmo_err
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [CW-1:0]   cnt_r;
    logic            dbz_r;
    logic            busy_unused_s;

    // div_busy carries no sequencing meaning here; it is only observed by checkers.
    assign busy_unused_s = div_busy;

    // State register: reset forces IDLE immediately, even mid-divide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: done has priority over the timeout in WAIT.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (req) begin
                    state_next_s = S_ISSUE;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_next_s = S_WAIT;
            end
            S_WAIT: begin
                if (div_done) begin
                    state_next_s = S_WRITE;
                end else if (cnt_r == CNT_LAST) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_WRITE: begin
                state_next_s = S_IDLE;
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // Output decode from the registered state; stall also covers the request cycle.
    always_comb begin
        div_start = 1'b0;
        ack       = 1'b0;
        dbz_exc   = 1'b0;
        tmo_err   = 1'b0;
        case (state_r)
            S_IDLE: begin
                div_start = 1'b0;
            end
            S_ISSUE: begin
                div_start = 1'b1;
            end
            S_WAIT: begin
                if (!div_done && (cnt_r == CNT_LAST)) begin
                    tmo_err = 1'b1;
                end else begin
                    tmo_err = 1'b0;
                end
            end
            S_WRITE: begin
                if (dbz_r) begin
                    dbz_exc = 1'b1;
                end else begin
                    ack = 1'b1;
                end
            end
            default: begin
                div_start = 1'b0;
            end
        endcase
        stall = (state_r != S_IDLE) | req;
    end

    // Datapath: operand latch, timeout counter, result capture and HI/LO writes.
    // Results are loaded into HI/LO on the done edge so they are already
    // visible in the WRITE cycle, alongside ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_a <= {WIDTH{1'b0}};
            div_b <= {WIDTH{1'b0}};
            hi    <= {WIDTH{1'b0}};
            lo    <= {WIDTH{1'b0}};
            cnt_r <= {CW{1'b0}};
            dbz_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (req) begin
                        div_a <= op_a;
                        div_b <= op_b;
                    end else begin
                        if (hi_we) begin
                            hi <= wdata;
                        end
                        if (lo_we) begin
                            lo <= wdata;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt_r <= {CW{1'b0}};
                end
                S_WAIT: begin
                    cnt_r <= cnt_r + CW'(1);
                    if (div_done) begin
                        dbz_r <= div_dbz;
                        if (!div_dbz) begin
                            lo <= div_val;
                            hi <= div_rem;
                        end
                    end
                end
                S_WRITE: begin
                    dbz_r <= dbz_r;
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: a behavioural divider model answers the
// start handshake; a scoreboard queue holds the expected event (ack, dbz or
// timeout), its cycle and the HI/LO contents, checked by a separate monitor.
module tb_div_ctrl;

    localparam int W   = 32;
    localparam int TMO = 64;
    localparam int K_ACK = 0;
    localparam int K_DBZ = 1;
    localparam int K_TMO = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req = 1'b0;
    logic [W-1:0]  op_a = '0;
    logic [W-1:0]  op_b = '0;
    logic          hi_we = 1'b0;
    logic          lo_we = 1'b0;
    logic [W-1:0]  wdata = '0;
    logic          div_start;
    logic [W-1:0]  div_a;
    logic [W-1:0]  div_b;
    logic          div_busy;
    logic          div_done;
    logic          div_dbz;
    logic [W-1:0]  div_val;
    logic [W-1:0]  div_rem;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          stall;
    logic          ack;
    logic          dbz_exc;
    logic          tmo_err;

    div_ctrl #(.WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_busy(div_busy), .div_done(div_done), .div_dbz(div_dbz),
        .div_val(div_val), .div_rem(div_rem),
        .hi(hi), .lo(lo), .stall(stall), .ack(ack),
        .dbz_exc(dbz_exc), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural divider model ----------------
    int   m_lat  = 1;
    bit   m_hang = 1'b0;
    int   m_cnt;
    bit   m_act;
    logic [W-1:0] md_q, md_r;

    always_comb begin
        md_q = 32'hBAD0BAD0;
        md_r = 32'hBAD1BAD1;
        if (div_b != 32'd0) begin
            md_q = $signed(div_a) / $signed(div_b);
            md_r = $signed(div_a) % $signed(div_b);
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_done <= 1'b0; div_dbz <= 1'b0; div_busy <= 1'b0;
            div_val <= '0; div_rem <= '0; m_act <= 1'b0; m_cnt <= 0;
        end else begin
            div_done <= 1'b0;
            if (div_start) begin
                div_busy <= 1'b1;
                if (!m_hang && m_lat <= 1) begin
                    div_done <= 1'b1; div_busy <= 1'b0; m_act <= 1'b0;
                    div_dbz <= (div_b == 32'd0); div_val <= md_q; div_rem <= md_r;
                end else begin
                    m_act <= !m_hang;
                    m_cnt <= m_lat - 1;
                end
            end else if (m_act) begin
                if (m_cnt <= 1) begin
                    div_done <= 1'b1; div_busy <= 1'b0; m_act <= 1'b0;
                    div_dbz <= (div_b == 32'd0); div_val <= md_q; div_rem <= md_r;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    // ---------------- scoreboard + monitor ----------------
    typedef struct {
        int           kind;
        logic [W-1:0] h;
        logic [W-1:0] l;
        int           at;
    } exp_t;
    exp_t sbq[$];
    logic [W-1:0] ref_hi = '0;
    logic [W-1:0] ref_lo = '0;
    int stall_total = 0;
    int start_total = 0;
    int ack_total   = 0;

    initial begin
        exp_t e;
        int   kind;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (stall)     stall_total++;
                if (div_start) start_total++;
                if (ack)       ack_total++;
                if (ack || dbz_exc || tmo_err) begin
                    chk("one_event_pulse", 32'({ack, dbz_exc, tmo_err} == 3'b100 ||
                        {ack, dbz_exc, tmo_err} == 3'b010 || {ack, dbz_exc, tmo_err} == 3'b001), 32'd1);
                    kind = ack ? K_ACK : (dbz_exc ? K_DBZ : K_TMO);
                    if (sbq.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_event: got kind %0d, expected none (cycle %0d)", kind, cyc);
                    end else begin
                        e = sbq.pop_front();
                        chk("event_kind", 32'(kind), 32'(e.kind));
                        chk("event_cycle", 32'(cyc), 32'(e.at));
                        chk("hi_at_event", hi, e.h);
                        chk("lo_at_event", lo, e.l);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int lat, input bit hang, input bit also_we);
        exp_t e;
        logic signed [W-1:0] sa, sb;
        @(posedge clk); #1;
        m_lat = lat; m_hang = hang;
        req = 1'b1; op_a = a; op_b = b;
        hi_we = also_we; wdata = $urandom;
        sa = a; sb = b;
        if (hang) begin
            e = '{K_TMO, ref_hi, ref_lo, cyc + 1 + TMO};
        end else if (b == 32'd0) begin
            e = '{K_DBZ, ref_hi, ref_lo, cyc + 2 + lat};
        end else begin
            ref_lo = sa / sb;
            ref_hi = sa % sb;
            e = '{K_ACK, ref_hi, ref_lo, cyc + 2 + lat};
        end
        sbq.push_back(e);
        @(posedge clk); #1;
        req = 1'b0; hi_we = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (stall && k < 300);
        chk("idle_within_budget", 32'(stall), 32'd0);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    endtask

    task automatic mt(input bit to_hi, input logic [W-1:0] d);
        @(posedge clk); #1;
        hi_we = to_hi; lo_we = !to_hi; wdata = d;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        if (to_hi) ref_hi = d; else ref_lo = d;
        chk("mthi_mtlo_hi", hi, ref_hi);
        chk("mthi_mtlo_lo", lo, ref_lo);
    endtask

    initial begin
        int snap_s, snap_a, snap_st;
        logic [W-1:0] ra, rb;
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_div_a", div_a, 32'd0);
        chk("rst_outs", {28'd0, div_start, ack, dbz_exc, tmo_err}, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        rst = 1'b1;

        // reset mid-WAIT
        mt(1'b1, 32'h55);
        mt(1'b0, 32'h66);
        issue(32'd100, 32'd7, 33, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        chk("midrst_div_b", div_b, 32'd0);
        sbq.delete();
        ref_hi = '0; ref_lo = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        issue(32'd100, 32'd7, 5, 1'b0, 1'b0);
        wait_idle();
        chk("post_rst_lo", lo, 32'd14);
        chk("post_rst_hi", hi, 32'd2);

        // basic, latency 33
        snap_s = stall_total; snap_st = start_total; snap_a = ack_total;
        issue(32'd7, 32'd3, 33, 1'b0, 1'b0);
        wait_idle();
        chk("basic_stall_cycles", 32'(stall_total - snap_s), 32'd36);
        chk("basic_start_cycles", 32'(start_total - snap_st), 32'd1);
        chk("basic_ack_count", 32'(ack_total - snap_a), 32'd1);
        chk("basic_lo", lo, 32'd2);
        chk("basic_hi", hi, 32'd1);

        // signed
        issue(32'hFFFF_FFF7, 32'd2, 4, 1'b0, 1'b0);
        wait_idle();
        chk("signed1_lo", lo, 32'hFFFF_FFFC);
        chk("signed1_hi", hi, 32'hFFFF_FFFF);
        issue(32'd9000, 32'hFFFF_FFFC, 1, 1'b0, 1'b0);
        wait_idle();
        chk("signed2_lo", lo, 32'hFFFF_F736);
        chk("signed2_hi", hi, 32'd0);

        // divide by zero
        mt(1'b1, 32'h11);
        mt(1'b0, 32'h22);
        snap_a = ack_total;
        issue(32'd5000, 32'd0, 10, 1'b0, 1'b0);
        wait_idle();
        chk("dbz_ack_count", 32'(ack_total - snap_a), 32'd0);
        chk("dbz_hi", hi, 32'h11);
        chk("dbz_lo", lo, 32'h22);

        // timeout
        snap_s = stall_total;
        issue(32'd77, 32'd5, 1, 1'b1, 1'b0);
        wait_idle();
        chk("tmo_stall_cycles", 32'(stall_total - snap_s), 32'(TMO + 2));
        chk("tmo_hi", hi, 32'h11);

        // illegal writes and request during WAIT
        snap_a = ack_total;
        issue(32'd1000, 32'd7, 20, 1'b0, 1'b0);
        @(posedge clk); #1;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD;
        req = 1'b1; op_a = 32'd5; op_b = 32'd1;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0; req = 1'b0;
        wait_idle();
        chk("illegal_ack_count", 32'(ack_total - snap_a), 32'd1);
        chk("illegal_lo", lo, 32'd142);
        chk("illegal_hi", hi, 32'd6);
        chk("illegal_div_a", div_a, 32'd1000);

        // randomized mix
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                mt(1'($urandom_range(0, 1)), $urandom);
            end else begin
                ra = $urandom;
                if (ra == 32'h8000_0000) ra = 32'd0;
                rb = $urandom >> $urandom_range(0, 31);
                if ($urandom_range(0, 1) == 1) rb = -rb;
                if ($urandom_range(0, 7) == 0) rb = 32'd0;
                issue(ra, rb, $urandom_range(1, 40), 1'b0, 1'($urandom_range(0, 1)));
                wait_idle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
